// File: rtl/iter_divider_if.sv
// ============================================================================
//  iter_divider_if : request/response bundle for the iterative divider
//  Revision 1.0
// ============================================================================
`default_nettype none

interface iter_divider_if #(
  parameter int WORD_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  is_signed;
  logic [WORD_WIDTH-1:0] dividend;
  logic [WORD_WIDTH-1:0] divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_WIDTH-1:0] quot;
  logic [WORD_WIDTH-1:0] rem;
  logic                  div_by_zero;
  logic                  overflow;

  modport master (
    output in_valid, is_signed, dividend, divisor, out_ready,
    input  in_ready, out_valid, quot, rem, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, is_signed, dividend, divisor, out_ready,
    output in_ready, out_valid, quot, rem, div_by_zero, overflow
  );
endinterface

`default_nettype wire

// File: rtl/iter_divider.sv
// ============================================================================
//  iter_divider : fixed-latency restoring divider, signed/unsigned, with
//                 divide-by-zero and signed-overflow handling
//  Revision 1.0
// ============================================================================
`default_nettype none

module iter_divider #(
  parameter int WORD_WIDTH = 8,
  parameter int CNT_WIDTH  = $clog2(WORD_WIDTH + 1)
) (
  input  wire logic     clk,
  input  wire logic     reset,
  iter_divider_if.slave dif
);

  localparam logic [WORD_WIDTH-1:0] c_all_ones  = '1;
  localparam logic [WORD_WIDTH-1:0] c_most_neg  = {1'b1, {(WORD_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0]  c_last_step = CNT_WIDTH'(WORD_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_CALC  = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WORD_WIDTH-1:0] r_dvd;
  logic [WORD_WIDTH-1:0] r_dvs;
  logic                  r_sgn;
  logic [WORD_WIDTH-1:0] r_mag_s;
  logic [WORD_WIDTH-1:0] r_q;
  logic [WORD_WIDTH:0]   r_acc;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_q_neg;
  logic                  r_r_neg;
  logic                  r_dbz;
  logic                  r_ovf;
  logic [WORD_WIDTH-1:0] r_quot;
  logic [WORD_WIDTH-1:0] r_rem;

  logic                  w_dvd_neg;
  logic                  w_dvs_neg;
  logic [WORD_WIDTH-1:0] w_mag_d;
  logic [WORD_WIDTH-1:0] w_mag_s;
  logic [WORD_WIDTH+1:0] w_shift;
  logic [WORD_WIDTH+1:0] w_diff;
  logic                  w_fits;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (dif.in_valid) w_state_nxt = S_PREP;
      S_PREP:  w_state_nxt = S_CALC;
      S_CALC:  if (r_cnt == c_last_step) w_state_nxt = S_FIXUP;
      S_FIXUP: w_state_nxt = S_DONE;
      S_DONE:  if (dif.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The partial remainder is kept one bit wider than the operands and the
  // shifted trial value one more, so the borrow of the trial subtraction is
  // an explicit bit even when an unsigned divisor has its MSB set.
  always_comb begin
    w_dvd_neg = r_sgn & r_dvd[WORD_WIDTH-1];
    w_dvs_neg = r_sgn & r_dvs[WORD_WIDTH-1];
    w_mag_d   = w_dvd_neg ? (~r_dvd + 1'b1) : r_dvd;
    w_mag_s   = w_dvs_neg ? (~r_dvs + 1'b1) : r_dvs;
    w_shift   = {r_acc, r_q[WORD_WIDTH-1]};
    w_diff    = w_shift - {2'b00, r_mag_s};
    w_fits    = ~w_diff[WORD_WIDTH+1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_sgn   <= 1'b0;
      r_mag_s <= '0;
      r_q     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dif.in_valid) begin
            r_dvd <= dif.dividend;
            r_dvs <= dif.divisor;
            r_sgn <= dif.is_signed;
          end
        end
        S_PREP: begin
          r_q     <= w_mag_d;
          r_mag_s <= w_mag_s;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_q_neg <= w_dvd_neg ^ w_dvs_neg;
          r_r_neg <= w_dvd_neg;
          r_dbz   <= (r_dvs == '0);
          r_ovf   <= r_sgn && (r_dvd == c_most_neg) && (r_dvs == c_all_ones);
        end
        S_CALC: begin
          r_acc <= w_fits ? w_diff[WORD_WIDTH:0] : w_shift[WORD_WIDTH:0];
          r_q   <= {r_q[WORD_WIDTH-2:0], w_fits};
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIXUP: begin
          // Exceptions still ran the full iteration so latency never varies.
          if (r_dbz) begin
            r_quot <= c_all_ones;
            r_rem  <= r_dvd;
          end else if (r_ovf) begin
            r_quot <= r_dvd;
            r_rem  <= '0;
          end else begin
            r_quot <= r_q_neg ? (~r_q + 1'b1) : r_q;
            r_rem  <= r_r_neg ? (~r_acc[WORD_WIDTH-1:0] + 1'b1) : r_acc[WORD_WIDTH-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign dif.in_ready    = (r_state == S_IDLE);
  assign dif.out_valid   = (r_state == S_DONE);
  assign dif.quot        = r_quot;
  assign dif.rem         = r_rem;
  assign dif.div_by_zero = (r_state == S_DONE) & r_dbz;
  assign dif.overflow    = (r_state == S_DONE) & r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_iter_divider.sv
// ============================================================================
//  tb_iter_divider : scoreboard bench for iter_divider against an integer model
//  Revision 1.0
// ============================================================================
`default_nettype none

module tb_iter_divider;

  localparam int W = 8;
  localparam int LAT = W + 3;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  iter_divider_if #(.WORD_WIDTH(W)) dif ();

  iter_divider #(.WORD_WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .dif   (dif)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: plain integer division, C-style truncation toward zero.
  function automatic exp_t model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   sa, sb;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (b == 0) begin
      e.q = '1;
      e.r = a;
      e.dbz = 1'b1;
    end else if (s && $signed(a) == -(2 ** (W - 1)) && $signed(b) == -1) begin
      e.q = a;
      e.r = '0;
      e.ovf = 1'b1;
    end else if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      e.q = W'(sa / sb);
      e.r = W'(sa % sb);
    end else begin
      e.q = W'(int'(a) / int'(b));
      e.r = W'(int'(a) % int'(b));
    end
    return e;
  endfunction

  exp_t         sb[$];
  exp_t         cur;
  bit           active = 1'b0;
  int           lat = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;
  bit           force_rdy = 1'b1;
  bit           rdy_val = 1'b0;

  // Monitor: owns the scoreboard; posedge sees pre-edge values, negedge sees
  // settled DUT outputs. Latency counts edges with the accepting edge as 1.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        sb.delete();
        active = 1'b0;
        lat    = 0;
        last_q = '0;
        last_r = '0;
      end else begin
        lat++;
        if (dif.out_valid && dif.out_ready && active) begin
          active = 1'b0;
          last_q = cur.q;
          last_r = cur.r;
        end
        if (dif.in_valid && dif.in_ready) begin
          sb.push_back(model(dif.is_signed, dif.dividend, dif.divisor));
          lat = 1;
        end
      end
      @(negedge clk);
      if (dif.out_valid) begin
        if (!active) begin
          if (sb.size() == 0) begin
            chk(1'b0, "spurious_out_valid", 1, 0);
          end else begin
            cur    = sb.pop_front();
            active = 1'b1;
            chk(lat == LAT, "latency", lat, LAT);
          end
        end
        if (active) begin
          chk(dif.quot == cur.q, "quot", dif.quot, cur.q);
          chk(dif.rem == cur.r, "rem", dif.rem, cur.r);
          chk({dif.div_by_zero, dif.overflow} == {cur.dbz, cur.ovf}, "flags",
              {dif.div_by_zero, dif.overflow}, {cur.dbz, cur.ovf});
        end
        chk(dif.in_ready == 1'b0, "in_ready_while_done", dif.in_ready, 0);
      end else begin
        chk({dif.div_by_zero, dif.overflow} == 2'b00, "flags_idle",
            {dif.div_by_zero, dif.overflow}, 0);
        if (dif.in_ready) begin
          chk(dif.quot == last_q, "quot_retained", dif.quot, last_q);
          chk(dif.rem == last_r, "rem_retained", dif.rem, last_r);
        end
      end
    end
  end

  initial begin
    dif.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      dif.out_ready = force_rdy ? rdy_val : ($urandom_range(3) != 0);
    end
  end

  task automatic send(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    @(negedge clk);
    dif.in_valid  = 1'b1;
    dif.is_signed = s;
    dif.dividend  = a;
    dif.divisor   = b;
    n = 0;
    forever begin
      @(posedge clk);
      if (dif.in_ready && !reset) break;
      n++;
      if (n > 200) begin
        chk(1'b0, "accept_timeout", n, 200);
        break;
      end
    end
    @(negedge clk);
    dif.in_valid = 1'b0;
    dif.dividend = W'($urandom);
    dif.divisor  = W'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || active) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(n < 500, "drain_timeout", n, 500);
  endtask

  initial begin
    logic [W-1:0] a, b;
    int n;
    dif.in_valid  = 1'b0;
    dif.is_signed = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;
    repeat (3) @(negedge clk);
    chk(dif.in_ready == 1'b1, "reset_in_ready", dif.in_ready, 1);
    chk(dif.out_valid == 1'b0, "reset_out_valid", dif.out_valid, 0);
    chk({dif.quot, dif.rem} == '0, "reset_quot_rem", {dif.quot, dif.rem}, 0);
    reset = 1'b0;

    force_rdy = 1'b1;
    rdy_val   = 1'b1;
    send(0, 8'd200, 8'd7);
    send(1, 8'hF9, 8'h02);
    send(1, 8'h07, 8'hFE);
    send(0, 8'h55, 8'h00);
    send(1, 8'h55, 8'h00);
    send(1, 8'h80, 8'hFF);
    send(0, 8'h80, 8'hFF);
    send(0, 8'hFF, 8'h80);
    drain();

    // Back-pressure: result held while a competing request waits.
    rdy_val = 1'b0;
    send(0, 8'd100, 8'd9);
    n = 0;
    while (!dif.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(dif.out_valid == 1'b1, "hold_result_seen", dif.out_valid, 1);
    dif.in_valid  = 1'b1;
    dif.is_signed = 1'b1;
    dif.dividend  = 8'h33;
    dif.divisor   = 8'hFB;
    repeat (5) @(negedge clk);
    chk(dif.out_valid == 1'b1, "hold_out_valid", dif.out_valid, 1);
    rdy_val = 1'b1;
    n = 0;
    forever begin
      @(posedge clk);
      if (dif.in_ready) break;
      n++;
      if (n > 20) begin
        chk(1'b0, "hold_accept_timeout", n, 20);
        break;
      end
    end
    @(negedge clk);
    dif.in_valid = 1'b0;
    drain();

    // Abandon a request mid-CALC with a one-cycle reset pulse.
    send(0, 8'd255, 8'd3);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk(dif.in_ready == 1'b1, "midreset_in_ready", dif.in_ready, 1);
    chk(dif.out_valid == 1'b0, "midreset_out_valid", dif.out_valid, 0);
    chk({dif.quot, dif.rem, dif.div_by_zero, dif.overflow} == '0, "midreset_outputs",
        {dif.quot, dif.rem, dif.div_by_zero, dif.overflow}, 0);
    send(0, 8'd255, 8'd255);
    drain();

    force_rdy = 1'b0;
    for (int i = 0; i < 80; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      case ($urandom_range(7))
        0: b = '0;
        1: begin a = 8'h80; b = 8'hFF; end
        2: b = W'($urandom_range(3));
        default: ;
      endcase
      send(1'($urandom), a, b);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/iter_divider.md
ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, operand and result width, legal range 2..64.
REQ-002 SHALL have parameter CNT_WIDTH, default $clog2(WORD_WIDTH+1), iteration counter width, not overridden by users.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port is_signed  input  1  1 = two's-complement operands, 0 = unsigned, sampled with the request.
REQ-008 SHALL have port dividend  input  WORD_WIDTH  left operand.
REQ-009 SHALL have port divisor  input  WORD_WIDTH  right operand.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have ports quot and rem  output  WORD_WIDTH each  quotient and remainder.
REQ-013 SHALL have ports div_by_zero and overflow  output  1 each  exception flags, valid with out_valid.

Function
REQ-014 SHALL accept a request on a rising edge where in_valid && in_ready, registering dividend, divisor and is_signed; inputs are ignored at all other times.
REQ-015 SHALL implement the FSM IDLE -> PREP -> CALC -> FIXUP -> DONE -> IDLE; in_ready = 1 only in IDLE.
REQ-016 PREP (1 cycle) SHALL latch the operand magnitudes (absolute values when is_signed, raw otherwise), record the quotient and remainder signs, clear the remainder accumulator and load the counter with 0.
REQ-017 CALC SHALL perform one restoring shift-subtract step per cycle for exactly WORD_WIDTH cycles, using a WORD_WIDTH+1 bit partial remainder so that an unsigned divisor with MSB set never wraps.
REQ-018 FIXUP (1 cycle) SHALL negate the quotient when the operand signs differ and negate the remainder when the dividend is negative (truncation toward zero, remainder takes dividend sign).
REQ-019 Latency SHALL be fixed: out_valid rises exactly WORD_WIDTH+3 cycles after the accepting edge, for every operand value including exceptions.
REQ-020 Divisor == 0 SHALL force quot = all ones, rem = original dividend, div_by_zero = 1, overflow = 0.
REQ-021 is_signed with dividend = most negative value and divisor = -1 SHALL force quot = dividend, rem = 0, overflow = 1, div_by_zero = 0.
REQ-022 DONE SHALL hold out_valid = 1 with quot, rem and flags stable until an edge with out_ready = 1, then return to IDLE with out_valid = 0.
REQ-023 in_ready SHALL NOT rise in the same cycle the result is consumed; the next request is accepted no earlier than the cycle after the DONE -> IDLE transition.
REQ-024 Flags SHALL be 0 whenever out_valid = 0; quot and rem SHALL retain their last values while idle.

Reset
REQ-025 reset high at any rising edge SHALL force state IDLE, counter 0, in_ready = 1, out_valid = 0, quot = 0, rem = 0, div_by_zero = 0, overflow = 0, overriding every other input that cycle.
REQ-026 reset asserted mid-operation SHALL abandon the request with no result produced.

Verification (WORD_WIDTH = 8)
REQ-027 Unsigned 200 / 7 -> quot 0x1C, rem 0x04, flags 0, out_valid exactly 11 cycles after acceptance.
REQ-028 Signed 0xF9 (-7) / 0x02 -> quot 0xFD, rem 0xFF; signed 0x07 / 0xFE -> quot 0xFD, rem 0x01.
REQ-029 0x55 / 0x00, unsigned and signed -> quot 0xFF, rem 0x55, div_by_zero 1, latency still 11.
REQ-030 Signed 0x80 / 0xFF -> quot 0x80, rem 0x00, overflow 1; same operands unsigned -> quot 0x00, rem 0x80, overflow 0.
REQ-031 out_ready held low 5 cycles after out_valid -> outputs stable, in_ready 0, new in_valid ignored; on release, one consume and then next request accepted.
REQ-032 reset pulse during CALC cycle 4 -> all outputs at reset values next cycle; following request 255 / 255 -> quot 0x01, rem 0x00.
